bcd_stopwatch: RTL
==================

// Module: bcd_stopwatch
// PURPOSE
//   Two-digit BCD stopwatch, the stage directly upstream of the 7-segment decoder.
//   Divides the board clock down to a count tick and keeps a decimal count 00..99.
//   Each 4-bit digit output drives one decoder instance (HEX0 = digit0, HEX1 = digit1).
//   Controlled by a start/stop push-button level and a clear pulse.
// PARAMETERS
//   DIV      5_000_000  clock cycles per count tick (50 MHz -> 10 Hz); legal range 2..2^24
//   DIV_W    24         width of the prescaler counter; must satisfy 2^DIV_W >= DIV
// PORTS
//   clk         in   1  board clock (50 MHz)
//   resetn      in   1  asynchronous, active-low reset
//   start_stop  in   1  level, already synchronised; each rising edge toggles run/hold
//   clr         in   1  synchronous clear, level-sensitive, overrides everything
//   dir         in   1  0 = count up, 1 = count down (present only with COUNT_DOWN_EN)
//   digit0      out  4  ones digit, BCD 0..9
//   digit1      out  4  tens digit, BCD 0..9
//   running     out  1  1 while in RUN
//   wrap        out  1  one-cycle pulse on a 99->00 (or 00->99) transition
// BEHAVIOUR
//   Reset (resetn=0, asynchronous): state=IDLE, digits=0, prescaler=0, ss_prev=0, running=0, wrap=0.
//   Edge detect: ss_prev <= start_stop every cycle; edge = start_stop & ~ss_prev.
//   FSM states: IDLE (count 00, stopped), RUN, HOLD (frozen, count non-zero or paused).
//     IDLE --edge--> RUN;  RUN --edge--> HOLD;  HOLD --edge--> RUN.
//     Any state --clr--> IDLE, with digits and prescaler zeroed in the same cycle.
//   State change takes effect on the clock edge that samples the detected edge.
//     running is registered and equals (state==RUN).
//   Prescaler: advances only in RUN. tick = (div_cnt==DIV-1); at tick, div_cnt <= 0.
//     In HOLD, div_cnt is frozen, so a resumed run keeps its sub-tick phase.
//   The first increment occurs DIV cycles after entering RUN from IDLE.
//   Up count on tick: digit0++; at 9, digit0 <= 0 and digit1++; 99 -> 00 with wrap=1 for one cycle.
//   Digits never hold 10..15; only values 0..9 are reachable.
//   Simultaneous events:
//     clr with tick: clr wins, no increment, no wrap.
//     clr with start_stop edge: clr wins; the edge is consumed (ss_prev is still updated).
//     tick with start_stop edge in RUN: the increment is applied, and state goes to HOLD.
//   resetn asserted mid-count: immediate return to reset values; no partial update.
// CONFIGURATION
//   COUNT_DOWN_EN defined:
//     dir port exists. dir=1 decrements on tick: digit0 0 -> 9 with a borrow from digit1.
//     00 -> 99 with wrap=1. dir is sampled only on tick cycles.
//   COUNT_DOWN_EN undefined:
//     dir port absent; up-count only; no down-count logic is synthesised.
// STRUCTURE
//   Package display_pkg: DIGIT_W=4, DIGIT_MAX=4'd9, state encoding IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
//   Sub-module tick_divider (params DIV, DIV_W; ports clk, resetn, en, clr, tick).
//     Implements the prescaler. The FSM and BCD cascade stay in bcd_stopwatch.
// TESTING  (bench uses DIV=4)
//   Reset with start_stop=0 -> digits 00, running=0, wrap=0; hold 10 cycles -> unchanged.
//   Pulse start_stop; 4*25 cycles after RUN entry -> digits read 2,5 (tens=2, ones=5);
//     running=1 throughout.
//   Run from 98: after 2 ticks -> 00; wrap high exactly 1 cycle, coincident with the 99->00 update.
//   Edge at count 07 -> HOLD; wait 40 cycles -> still 07; edge again -> 08 after the remaining sub-tick cycles.
//   Assert clr on a tick cycle at 42 -> next cycle 00, IDLE, wrap=0.
//     Also deassert resetn mid-run -> 00 asynchronously.
//   COUNT_DOWN_EN, dir=1, from 00: one tick -> 99 with a wrap pulse; next tick -> 98; from 10 one tick -> 09.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch.
// Provides: digit width/limit, stopwatch state encoding.
// Optional feature macro: COUNT_DOWN_EN (adds the dir port and down-count path).
package display_pkg;

    localparam int               DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sw_state_e;

endpackage : display_pkg

// File: rtl/tick_divider.sv
// Prescaler: pulses tick for one cycle every DIV enabled cycles.
// Latency: tick is combinational from the registered count (asserted while div_cnt==DIV-1 and en).
// Backpressure: none; en freezes the count (phase kept), clr zeroes it and overrides en.
// Ports: clk, resetn (async active-low), en, clr (sync), tick.
module tick_divider #(
    parameter int DIV   = 5_000_000,
    parameter int DIV_W = 24
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             at_last;

    assign at_last = (div_cnt_q == DIV_W'(DIV - 1));
    // Gate with en: a frozen count may sit at DIV-1 while holding.
    assign tick    = en && at_last;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = at_last ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule : tick_divider

// File: rtl/bcd_stopwatch.sv
// Two-digit BCD stopwatch 00..99 feeding the 7-segment decoders (digit0=ones, digit1=tens).
// Latency: digits/running/wrap are registered; a count update appears on the edge sampling the tick.
// Backpressure: none; start_stop rising edges toggle run/hold, clr overrides everything.
// Ports: clk, resetn (async active-low), start_stop (level), clr (sync), dir (COUNT_DOWN_EN only),
//        digit0, digit1, running, wrap.
// Optional feature macro: COUNT_DOWN_EN.
module bcd_stopwatch
    import display_pkg::*;
#(
    parameter int DIV   = 5_000_000,
    parameter int DIV_W = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_stop,
    input  logic               clr,
`ifdef COUNT_DOWN_EN
    input  logic               dir,
`endif
    output logic [DIGIT_W-1:0] digit0,
    output logic [DIGIT_W-1:0] digit1,
    output logic               running,
    output logic               wrap
);

    sw_state_e          state_q, state_d;
    logic               ss_prev_q;
    logic               ss_edge;
    logic               tick;
    logic [DIGIT_W-1:0] d0_q, d0_d;
    logic [DIGIT_W-1:0] d1_q, d1_d;
    logic               running_q;
    logic               wrap_q, wrap_d;

    assign ss_edge = start_stop & ~ss_prev_q;

    tick_divider #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .resetn (resetn),
        .en     (state_q == RUN),
        .clr    (clr),
        .tick   (tick)
    );

    // Next-state: clr always wins and consumes any simultaneous edge.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (ss_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = HOLD;
                HOLD:    state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // BCD cascade. A tick is applied even when a start_stop edge moves RUN to HOLD.
    always_comb begin
        d0_d   = d0_q;
        d1_d   = d1_q;
        wrap_d = 1'b0;
        if (clr) begin
            d0_d = '0;
            d1_d = '0;
        end else if (tick) begin
`ifdef COUNT_DOWN_EN
            if (dir) begin
                if (d0_q == '0) begin
                    d0_d = DIGIT_MAX;
                    if (d1_q == '0) begin
                        d1_d   = DIGIT_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        d1_d = d1_q - 1'b1;
                    end
                end else begin
                    d0_d = d0_q - 1'b1;
                end
            end else
`endif
            begin
                if (d0_q == DIGIT_MAX) begin
                    d0_d = '0;
                    if (d1_q == DIGIT_MAX) begin
                        d1_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        d1_d = d1_q + 1'b1;
                    end
                end else begin
                    d0_d = d0_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ss_prev_q <= 1'b0;
            d0_q      <= '0;
            d1_q      <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_prev_q <= start_stop;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            running_q <= (state_d == RUN);
            wrap_q    <= wrap_d;
        end
    end

    assign digit0  = d0_q;
    assign digit1  = d1_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule : bcd_stopwatch
